am4_uctl: RTL and testbench

AM4_UCTL -- requirements
Module: am4_uctl

---
 rtl/am4_pkg.sv | 31 +++
 rtl/am4_cmux.sv | 35 +++
 rtl/am4_uctl.sv | 88 ++++++++
 tb/tb_am4_uctl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/am4_pkg.sv
// Shared constants for the am4 microprogram controller: sequencer opcodes
// (Am2910-style, 4-bit) and condition-select codes for the condition mux.
package am4_pkg;

   typedef enum logic [3:0] {
      OP_JZ   = 4'd0,
      OP_CJS  = 4'd1,
      OP_JMAP = 4'd2,
      OP_CJP  = 4'd3,
      OP_PUSH = 4'd4,
      OP_JSRP = 4'd5,
      OP_CJV  = 4'd6,
      OP_JRP  = 4'd7,
      OP_RFCT = 4'd8,
      OP_RPCT = 4'd9,
      OP_CRTN = 4'd10,
      OP_CJPP = 4'd11,
      OP_LDCT = 4'd12,
      OP_LOOP = 4'd13,
      OP_CONT = 4'd14,
      OP_JP   = 4'd15
   } am4_op_e;

   // Condition-select codes; external flags start at CS_CC0.
   localparam logic [3:0] CS_TRUE  = 4'd0;
   localparam logic [3:0] CS_CNZ   = 4'd1;
   localparam logic [3:0] CS_CZ    = 4'd2;
   localparam logic [3:0] CS_FALSE = 4'd3;
   localparam logic [3:0] CS_CC0   = 4'd4;

endpackage

// File: rtl/am4_cmux.sv
// Condition mux plus polarity control. Selects a counter-derived, constant or
// external condition by csel and XORs it with cinv. Purely combinational.
module am4_cmux
   import am4_pkg::*;
#(
   parameter int CC_W = 8
) (
   input  logic [3:0]      i_csel,
   input  logic            i_cinv,
   input  logic            i_cz,
   input  logic [CC_W-1:0] i_cc,
   output logic            o_tst
);

   logic w_sel;

   // Select the raw condition; unused codes above the flag range read as 0.
   always_comb begin
      w_sel = 1'b0;
      case (i_csel)
         CS_TRUE:  w_sel = 1'b1;
         CS_CNZ:   w_sel = ~i_cz;
         CS_CZ:    w_sel = i_cz;
         CS_FALSE: w_sel = 1'b0;
         default: begin
            for (int k = 0; k < CC_W; k++) begin
               if (int'(i_csel) == int'(CS_CC0) + k) w_sel = i_cc[k];
            end
         end
      endcase
   end

   assign o_tst = w_sel ^ i_cinv;

endmodule

// File: rtl/am4_uctl.sv
// am4 microprogram controller: pipeline register for the next microword, loop
// counter, and condition selection feeding an external sequencer.
// Build option: define AM4_CC_LATCH_EN to register cc before the condition
// mux (one-cycle condition latency); undefined, cc feeds the mux directly.
module am4_uctl
   import am4_pkg::*;
#(
   parameter int AM4_ADDR_WIDTH = 10,
   parameter int AM4_CC_WIDTH   = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ena,
   input  logic [AM4_ADDR_WIDTH+8:0] mi,
   input  logic [AM4_ADDR_WIDTH-1:0] map,
   input  logic [AM4_CC_WIDTH-1:0]   cc,
   input  logic                      ctl_n,
   input  logic                      cte_n,
   input  logic                      me_n,
   output logic [3:0]                i,
   output logic [AM4_ADDR_WIDTH-1:0] d,
   output logic                      tst,
   output logic                      cz
);

   localparam int AW = AM4_ADDR_WIDTH;

   logic [3:0]    r_op;
   logic [3:0]    r_csel;
   logic          r_cinv;
   logic [AW-1:0] r_addr;
   logic [AW-1:0] r_cnt;
   logic [AM4_CC_WIDTH-1:0] w_cc;

   // Pipeline register: capture the next microword {seq_op, csel, cinv, addr}.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op   <= OP_JZ;
         r_csel <= CS_TRUE;
         r_cinv <= 1'b0;
         r_addr <= '0;
      end else if (ena) begin
         r_op   <= mi[AW+8:AW+5];
         r_csel <= mi[AW+4:AW+1];
         r_cinv <= mi[AW];
         r_addr <= mi[AW-1:0];
      end
   end

   assign i  = r_op;
   assign d  = me_n ? r_addr : map;
   assign cz = (r_cnt == '0);

   // Loop counter: load from d (load beats count), else saturating decrement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (ena) begin
         if (!ctl_n)               r_cnt <= d;
         else if (!cte_n && !cz)   r_cnt <= r_cnt - 1'b1;
      end
   end

`ifdef AM4_CC_LATCH_EN
   logic [AM4_CC_WIDTH-1:0] r_cc;

   // Condition latch: sample external flags on each enabled edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   r_cc <= '0;
      else if (ena) r_cc <= cc;
   end

   assign w_cc = r_cc;
`else
   assign w_cc = cc;
`endif

   am4_cmux #(
      .CC_W (AM4_CC_WIDTH)
   ) u_cmux (
      .i_csel (r_csel),
      .i_cinv (r_cinv),
      .i_cz   (cz),
      .i_cc   (w_cc),
      .o_tst  (tst)
   );

endmodule

// File: tb/tb_am4_uctl.sv
// Directed self-checking bench for am4_uctl (default parameters).
module tb_am4_uctl;
   import am4_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        ena;
   logic [18:0] mi;
   logic [9:0]  map;
   logic [7:0]  cc;
   logic        ctl_n, cte_n, me_n;
   logic [3:0]  i;
   logic [9:0]  d;
   logic        tst, cz;

   int n_vec = 0;
   int n_err = 0;

   am4_uctl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .mi    (mi),
      .map   (map),
      .cc    (cc),
      .ctl_n (ctl_n),
      .cte_n (cte_n),
      .me_n  (me_n),
      .i     (i),
      .d     (d),
      .tst   (tst),
      .cz    (cz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [18:0] mk(input logic [3:0] op, input logic [3:0] cs,
                                      input logic inv, input logic [9:0] a);
      return {op, cs, inv, a};
   endfunction

   // Advance one edge; inputs are driven and outputs sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ena = 1'b1; mi = '1; map = 10'h3C3; cc = '0;
      ctl_n = 1'b1; cte_n = 1'b1; me_n = 1'b1;
      repeat (3) tick();
      n_vec++; if (i !== 4'd0)    begin n_err++; $display("FAIL reset_i got %h exp 0", i); end
      n_vec++; if (tst !== 1'b1)  begin n_err++; $display("FAIL reset_tst got %b exp 1", tst); end
      n_vec++; if (cz !== 1'b1)   begin n_err++; $display("FAIL reset_cz got %b exp 1", cz); end
      n_vec++; if (dut.r_cnt !== 10'd0) begin n_err++; $display("FAIL reset_cnt got %h exp 0", dut.r_cnt); end
      n_vec++; if (d !== 10'd0)   begin n_err++; $display("FAIL reset_d got %h exp 0", d); end
      me_n = 1'b0; #1;
      n_vec++; if (d !== 10'h3C3) begin n_err++; $display("FAIL reset_dmap got %h exp 3c3", d); end
      me_n = 1'b1;
      mi = mk(OP_CONT, CS_TRUE, 1'b0, 10'd0);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_load_count();
      int  exp_c [5] = '{3, 2, 1, 0, 0};
      logic exp_t [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      mi = mk(OP_CONT, CS_CNZ, 1'b0, 10'd3);
      tick();
      ctl_n = 1'b0;
      tick();
      ctl_n = 1'b1; cte_n = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n_vec++;
         if (dut.r_cnt !== 10'(exp_c[k])) begin
            n_err++; $display("FAIL count_%0d got %0d exp %0d", k, dut.r_cnt, exp_c[k]);
         end
         n_vec++;
         if (tst !== exp_t[k]) begin
            n_err++; $display("FAIL count_tst_%0d got %b exp %b", k, tst, exp_t[k]);
         end
         tick();
      end
      n_vec++; if (dut.r_cnt !== 10'd0) begin n_err++; $display("FAIL count_nowrap got %h exp 0", dut.r_cnt); end
      n_vec++; if (cz !== 1'b1) begin n_err++; $display("FAIL count_cz got %b exp 1", cz); end
      cte_n = 1'b1;
   endtask

   task automatic test_priority();
      mi = mk(OP_CONT, CS_TRUE, 1'b0, 10'd5);
      tick();
      ctl_n = 1'b0;
      tick();
      ctl_n = 1'b1;
      mi = mk(OP_CONT, CS_TRUE, 1'b0, 10'd9);
      tick();
      n_vec++; if (dut.r_cnt !== 10'd5) begin n_err++; $display("FAIL prio_pre got %0d exp 5", dut.r_cnt); end
      ctl_n = 1'b0; cte_n = 1'b0;
      tick();
      ctl_n = 1'b1; cte_n = 1'b1;
      n_vec++; if (dut.r_cnt !== 10'd9) begin n_err++; $display("FAIL prio_load got %0d exp 9", dut.r_cnt); end
   endtask

   task automatic test_map();
      mi = mk(OP_JMAP, CS_TRUE, 1'b0, 10'h011);
      tick();
      me_n = 1'b0; map = 10'h2A5; #1;
      n_vec++; if (d !== 10'h2A5) begin n_err++; $display("FAIL map_sel got %h exp 2a5", d); end
      me_n = 1'b1; #1;
      n_vec++; if (d !== 10'h011) begin n_err++; $display("FAIL map_addr got %h exp 011", d); end
      me_n = 1'b0; ctl_n = 1'b0;
      tick();
      me_n = 1'b1; ctl_n = 1'b1;
      n_vec++; if (dut.r_cnt !== 10'h2A5) begin n_err++; $display("FAIL map_load got %h exp 2a5", dut.r_cnt); end
      n_vec++; if (i !== OP_JMAP) begin n_err++; $display("FAIL map_i got %h exp 2", i); end
   endtask

   task automatic test_cond();
      cc = 8'h00;
      mi = mk(OP_CJP, 4'd6, 1'b0, 10'd0);
      tick();
      n_vec++; if (tst !== 1'b0) begin n_err++; $display("FAIL cond_cc0 got %b exp 0", tst); end
      cc = 8'b0000_0100; #1;
`ifdef AM4_CC_LATCH_EN
      n_vec++; if (tst !== 1'b0) begin n_err++; $display("FAIL cond_lat_pre got %b exp 0", tst); end
      tick();
`endif
      n_vec++; if (tst !== 1'b1) begin n_err++; $display("FAIL cond_sel got %b exp 1", tst); end
      mi = mk(OP_CJP, 4'd6, 1'b1, 10'd0);
      tick();
      n_vec++; if (tst !== 1'b0) begin n_err++; $display("FAIL cond_inv got %b exp 0", tst); end
      mi = mk(OP_CJP, 4'd15, 1'b0, 10'd0);
      cc = 8'hFF;
      tick();
      tick();
      n_vec++; if (tst !== 1'b0) begin n_err++; $display("FAIL cond_c15 got %b exp 0", tst); end
      mi = mk(OP_CJP, 4'd12, 1'b0, 10'd0);
      tick();
      n_vec++; if (tst !== 1'b0) begin n_err++; $display("FAIL cond_c12 got %b exp 0", tst); end
      mi = mk(OP_CJP, 4'd11, 1'b0, 10'd0);
      cc = 8'h80;
      tick();
      tick();
      n_vec++; if (tst !== 1'b1) begin n_err++; $display("FAIL cond_c11 got %b exp 1", tst); end
      mi = mk(OP_CJP, CS_FALSE, 1'b0, 10'd0);
      tick();
      n_vec++; if (tst !== 1'b0) begin n_err++; $display("FAIL cond_false got %b exp 0", tst); end
      mi = mk(OP_CJP, CS_CZ, 1'b0, 10'd0);
      tick();
      n_vec++; if (tst !== 1'b0) begin n_err++; $display("FAIL cond_cz got %b exp 0", tst); end
      cc = 8'h00;
   endtask

   task automatic test_ena();
      mi = mk(OP_CONT, CS_TRUE, 1'b0, 10'd7);
      tick();
      ctl_n = 1'b0;
      tick();
      ctl_n = 1'b1;
      ena = 1'b0; cte_n = 1'b0;
      mi = mk(OP_JP, 4'd2, 1'b1, 10'h3FF);
      repeat (4) tick();
      n_vec++; if (dut.r_cnt !== 10'd7) begin n_err++; $display("FAIL ena_cnt got %0d exp 7", dut.r_cnt); end
      n_vec++; if (i !== OP_CONT) begin n_err++; $display("FAIL ena_i got %h exp e", i); end
      n_vec++; if (d !== 10'd7) begin n_err++; $display("FAIL ena_addr got %h exp 007", d); end
      ena = 1'b1;
      tick();
      n_vec++; if (dut.r_cnt !== 10'd6) begin n_err++; $display("FAIL ena_resume got %0d exp 6", dut.r_cnt); end
      n_vec++; if (i !== OP_JP) begin n_err++; $display("FAIL ena_i2 got %h exp f", i); end
      cte_n = 1'b1;
   endtask

   task automatic test_reset_mid();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      n_vec++; if (dut.r_cnt !== 10'd0) begin n_err++; $display("FAIL rmid_cnt got %0d exp 0", dut.r_cnt); end
      n_vec++; if (i !== 4'd0) begin n_err++; $display("FAIL rmid_i got %h exp 0", i); end
      n_vec++; if (tst !== 1'b1) begin n_err++; $display("FAIL rmid_tst got %b exp 1", tst); end
      tick();
      mi = mk(OP_CJP, CS_CNZ, 1'b1, 10'h155);
      rst_n = 1'b1;
      tick();
      n_vec++; if (i !== OP_CJP) begin n_err++; $display("FAIL rmid_load_i got %h exp 3", i); end
      n_vec++; if (d !== 10'h155) begin n_err++; $display("FAIL rmid_load_d got %h exp 155", d); end
      n_vec++; if (tst !== 1'b1) begin n_err++; $display("FAIL rmid_load_tst got %b exp 1", tst); end
   endtask

   initial begin
      test_reset();
      test_load_count();
      test_priority();
      test_map();
      test_cond();
      test_ena();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
